// File: rtl/ex_stage_mc.sv
// ---------------------------------------------------------------------------
// ex_stage_mc -- execute stage with a single-cycle ALU, an iterative
// shift-add multiplier and the EX/MEM pipeline register.
//
// The stage selects operand B (register or sign-extended immediate), runs the
// ALU and registers the result together with the store data, the destination
// register and the MEM/WB control fields. A multiply runs for DATA_WIDTH extra
// edges after issue. BusyOut asks ID/EX to hold its outputs while it runs.
//
// Optional feature macro: EX_FORWARD_EN
//   When defined, the ForwardAIn/ForwardBIn selects and the MemResultIn/
//   WbDataIn bypass buses are added. Both forwarding muxes sit in front of
//   the ALUSrc mux, and the B mux also feeds the store data.
//
// Ports
//   Clk, RstN          clock (rising edge), asynchronous active-low reset
//   ValidIn, FlushIn   ID/EX holds a valid instruction; squash EX next edge
//   EXControlIn[3:0]   [3] RegDst, [2:1] ALUOp, [0] ALUSrc
//   MEMControlIn, WBControlIn   control forwarded unchanged to MEM/WB
//   FunctIn[2:0]       operation select when ALUOp=10
//   DataAIn, DataBIn, SEIn      operands and sign-extended immediate
//   RtIn, RdIn         destination candidates
//   ResultOut, DataOut, MEMControlOut, WBControlOut, RdOut, ValidOut
//                      EX/MEM register outputs
//   BusyOut            combinational stall request toward ID/EX
// ---------------------------------------------------------------------------
module ex_stage_mc #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_CTRL_WIDTH = 2,
  parameter int WB_CTRL_WIDTH  = 2
) (
  input  logic                      Clk,
  input  logic                      RstN,
  input  logic                      ValidIn,
  input  logic                      FlushIn,
  input  logic [3:0]                EXControlIn,
  input  logic [MEM_CTRL_WIDTH-1:0] MEMControlIn,
  input  logic [WB_CTRL_WIDTH-1:0]  WBControlIn,
  input  logic [2:0]                FunctIn,
  input  logic [DATA_WIDTH-1:0]     DataAIn,
  input  logic [DATA_WIDTH-1:0]     DataBIn,
  input  logic [DATA_WIDTH-1:0]     SEIn,
  input  logic [REG_ADDR_WIDTH-1:0] RtIn,
  input  logic [REG_ADDR_WIDTH-1:0] RdIn,
`ifdef EX_FORWARD_EN
  input  logic [1:0]                ForwardAIn,
  input  logic [1:0]                ForwardBIn,
  input  logic [DATA_WIDTH-1:0]     MemResultIn,
  input  logic [DATA_WIDTH-1:0]     WbDataIn,
`endif
  output logic [DATA_WIDTH-1:0]     ResultOut,
  output logic [DATA_WIDTH-1:0]     DataOut,
  output logic [MEM_CTRL_WIDTH-1:0] MEMControlOut,
  output logic [WB_CTRL_WIDTH-1:0]  WBControlOut,
  output logic [REG_ADDR_WIDTH-1:0] RdOut,
  output logic                      ValidOut,
  output logic                      BusyOut
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  // ALU operation, evaluated on the selected operands
  function automatic logic [DATA_WIDTH-1:0] alu_f(
    input logic [1:0]            alu_op,
    input logic [2:0]            funct,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
    sa = a;
    sb = b;
    alu_f = '0;
    case (alu_op)
      2'b00: alu_f = a + b;
      2'b01: alu_f = a - b;
      2'b11: alu_f = a | b;
      default: begin
        case (funct)
          3'b000: alu_f = a + b;
          3'b001: alu_f = a - b;
          3'b010: alu_f = a & b;
          3'b011: alu_f = a | b;
          3'b100: alu_f = a ^ b;
          3'b101: alu_f = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
          3'b110: alu_f = a << b[CNT_W-1:0];
          default: alu_f = '0;  // mul is handled by the iterative unit
        endcase
      end
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Operand selection
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] store_b;
  logic [DATA_WIDTH-1:0] op_b;

`ifdef EX_FORWARD_EN
  always_comb begin
    op_a = DataAIn;
    case (ForwardAIn)
      2'b01:   op_a = MemResultIn;
      2'b10:   op_a = WbDataIn;
      default: op_a = DataAIn;
    endcase
    store_b = DataBIn;
    case (ForwardBIn)
      2'b01:   store_b = MemResultIn;
      2'b10:   store_b = WbDataIn;
      default: store_b = DataBIn;
    endcase
  end
`else
  assign op_a    = DataAIn;
  assign store_b = DataBIn;
`endif

  assign op_b = EXControlIn[0] ? SEIn : store_b;

  logic                      is_mul;
  logic [DATA_WIDTH-1:0]     alu_res;
  logic [REG_ADDR_WIDTH-1:0] dest;

  assign is_mul  = (EXControlIn[2:1] == 2'b10) && (FunctIn == 3'b111);
  assign alu_res = alu_f(EXControlIn[2:1], FunctIn, op_a, op_b);
  assign dest    = EXControlIn[3] ? RdIn : RtIn;

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_mul, step_mul, cap_alu, cap_mul;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_mul = 1'b0;
    step_mul = 1'b0;
    cap_alu  = 1'b0;
    cap_mul  = 1'b0;
    BusyOut  = 1'b0;
    if (FlushIn) begin
      // Squash whatever is in flight; the EX/MEM side sees a bubble.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ValidIn) begin
            if (is_mul) begin
              load_mul = 1'b1;
              cnt_d    = CNT_LAST;
              state_d  = S_MUL;
              BusyOut  = 1'b1;
            end else begin
              cap_alu = 1'b1;
            end
          end
        end
        default: begin
          step_mul = 1'b1;
          if (cnt_q == '0) begin
            // Busy drops here so ID/EX advances on the completing edge.
            cap_mul = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
            BusyOut = 1'b1;
          end
        end
      endcase
    end
    // Reset is asynchronous, so the stall request must vanish with it.
    if (!RstN) BusyOut = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Multiplier datapath (state sampled at issue, ignores inputs afterwards)
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]     mcand_q, mplier_q, acc_q, acc_next;
  logic [DATA_WIDTH-1:0]     mst_q;
  logic [REG_ADDR_WIDTH-1:0] mrd_q;
  logic [MEM_CTRL_WIDTH-1:0] mmem_q;
  logic [WB_CTRL_WIDTH-1:0]  mwb_q;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge Clk) begin
    if (load_mul) begin
      mcand_q  <= op_a;
      mplier_q <= op_b;
      acc_q    <= '0;
      mst_q    <= store_b;
      mrd_q    <= dest;
      mmem_q   <= MEMControlIn;
      mwb_q    <= WBControlIn;
    end else if (step_mul) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  // -------------------------------------------------------------------------
  // EX/MEM pipeline register
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ResultOut     <= '0;
      DataOut       <= '0;
      MEMControlOut <= '0;
      WBControlOut  <= '0;
      RdOut         <= '0;
      ValidOut      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap_alu) begin
        ResultOut     <= alu_res;
        DataOut       <= store_b;
        MEMControlOut <= MEMControlIn;
        WBControlOut  <= WBControlIn;
        RdOut         <= dest;
        ValidOut      <= 1'b1;
      end else if (cap_mul) begin
        ResultOut     <= acc_next;
        DataOut       <= mst_q;
        MEMControlOut <= mmem_q;
        WBControlOut  <= mwb_q;
        RdOut         <= mrd_q;
        ValidOut      <= 1'b1;
      end else begin
        // Bubble: data fields hold, control fields are cleared.
        MEMControlOut <= '0;
        WBControlOut  <= '0;
        ValidOut      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
module tb_ex_stage_mc;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          RstN = 1'b0;
  logic          ValidIn = 1'b0;
  logic          FlushIn = 1'b0;
  logic [3:0]    EXControlIn = '0;
  logic [1:0]    MEMControlIn = '0;
  logic [1:0]    WBControlIn = '0;
  logic [2:0]    FunctIn = '0;
  logic [DW-1:0] DataAIn = '0, DataBIn = '0, SEIn = '0;
  logic [4:0]    RtIn = '0, RdIn = '0;
`ifdef EX_FORWARD_EN
  logic [1:0]    ForwardAIn = '0, ForwardBIn = '0;
  logic [DW-1:0] MemResultIn = '0, WbDataIn = '0;
`endif
  logic [DW-1:0] ResultOut, DataOut;
  logic [1:0]    MEMControlOut, WBControlOut;
  logic [4:0]    RdOut;
  logic          ValidOut, BusyOut;

  ex_stage_mc #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(5), .MEM_CTRL_WIDTH(2), .WB_CTRL_WIDTH(2)) dut (
    .Clk(Clk), .RstN(RstN), .ValidIn(ValidIn), .FlushIn(FlushIn),
    .EXControlIn(EXControlIn), .MEMControlIn(MEMControlIn), .WBControlIn(WBControlIn),
    .FunctIn(FunctIn), .DataAIn(DataAIn), .DataBIn(DataBIn), .SEIn(SEIn),
    .RtIn(RtIn), .RdIn(RdIn),
`ifdef EX_FORWARD_EN
    .ForwardAIn(ForwardAIn), .ForwardBIn(ForwardBIn),
    .MemResultIn(MemResultIn), .WbDataIn(WbDataIn),
`endif
    .ResultOut(ResultOut), .DataOut(DataOut), .MEMControlOut(MEMControlOut),
    .WBControlOut(WBControlOut), .RdOut(RdOut), .ValidOut(ValidOut), .BusyOut(BusyOut)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_op(input logic [3:0] exc, input logic [2:0] f,
                        input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] se,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [1:0] mem, input logic [1:0] wb);
    EXControlIn = exc; FunctIn = f; DataAIn = a; DataBIn = b; SEIn = se;
    RtIn = rt; RdIn = rd; MEMControlIn = mem; WBControlIn = wb;
  endtask

  typedef struct {
    logic [3:0]    exc;
    logic [2:0]    funct;
    logic [DW-1:0] a, b, se;
    logic [4:0]    rt, rd;
    logic [1:0]    mem, wb;
    logic [DW-1:0] exp_res, exp_data;
    logic [4:0]    exp_rd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int busy_cnt;
    int valid_early;

    vecs[0]  = '{4'b1101, 3'b010, 32'd4, 32'd8, 32'hffffffff, 5'd8, 5'd9, 2'b01, 2'b11, 32'd4, 32'd8, 5'd9};
    vecs[1]  = '{4'b0000, 3'b000, 32'hffffffff, 32'd1, 32'd0, 5'd3, 5'd7, 2'b10, 2'b01, 32'd0, 32'd1, 5'd3};
    vecs[2]  = '{4'b1100, 3'b101, 32'hffffffff, 32'd1, 32'd0, 5'd1, 5'd2, 2'b00, 2'b11, 32'd1, 32'd1, 5'd2};
    vecs[3]  = '{4'b1010, 3'b000, 32'd10, 32'd3, 32'd0, 5'd4, 5'd5, 2'b11, 2'b00, 32'd7, 32'd3, 5'd5};
    vecs[4]  = '{4'b0110, 3'b000, 32'hf0, 32'h0f, 32'd0, 5'd6, 5'd7, 2'b01, 2'b01, 32'hff, 32'h0f, 5'd6};
    vecs[5]  = '{4'b1100, 3'b000, 32'd5, 32'd6, 32'd0, 5'd1, 5'd8, 2'b10, 2'b10, 32'd11, 32'd6, 5'd8};
    vecs[6]  = '{4'b1100, 3'b001, 32'd3, 32'd5, 32'd0, 5'd1, 5'd9, 2'b01, 2'b10, 32'hfffffffe, 32'd5, 5'd9};
    vecs[7]  = '{4'b1100, 3'b011, 32'h10, 32'h01, 32'd0, 5'd1, 5'd10, 2'b11, 2'b11, 32'h11, 32'h01, 5'd10};
    vecs[8]  = '{4'b1100, 3'b100, 32'hff, 32'h0f, 32'd0, 5'd1, 5'd11, 2'b10, 2'b01, 32'hf0, 32'h0f, 5'd11};
    vecs[9]  = '{4'b1100, 3'b110, 32'd1, 32'h24, 32'd0, 5'd1, 5'd12, 2'b01, 2'b01, 32'h10, 32'h24, 5'd12};
    vecs[10] = '{4'b1100, 3'b101, 32'd1, 32'hffffffff, 32'd0, 5'd1, 5'd13, 2'b11, 2'b10, 32'd0, 32'hffffffff, 5'd13};
    vecs[11] = '{4'b0001, 3'b000, 32'd10, 32'd77, 32'hfffffffe, 5'd14, 5'd15, 2'b10, 2'b11, 32'd8, 32'd77, 5'd14};

    // Reset state
    #12;
    chk("rst_result", ResultOut, 0);
    chk("rst_data", DataOut, 0);
    chk("rst_rd", RdOut, 0);
    chk("rst_ctrl", {MEMControlOut, WBControlOut}, 0);
    chk("rst_valid", ValidOut, 0);
    chk("rst_busy", BusyOut, 0);
    @(negedge Clk);
    RstN = 1'b1;

    // Single-cycle ALU vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      set_op(vecs[i].exc, vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].se,
             vecs[i].rt, vecs[i].rd, vecs[i].mem, vecs[i].wb);
      ValidIn = 1'b1;
      #1 chk($sformatf("v%0d_busy", i), BusyOut, 0);
      @(posedge Clk); #1;
      chk($sformatf("v%0d_result", i), ResultOut, vecs[i].exp_res);
      chk($sformatf("v%0d_data", i), DataOut, vecs[i].exp_data);
      chk($sformatf("v%0d_rd", i), RdOut, vecs[i].exp_rd);
      chk($sformatf("v%0d_mem", i), MEMControlOut, vecs[i].mem);
      chk($sformatf("v%0d_wb", i), WBControlOut, vecs[i].wb);
      chk($sformatf("v%0d_valid", i), ValidOut, 1);
    end

    // Bubble: controls cleared, data fields hold
    @(negedge Clk);
    ValidIn = 1'b0;
    set_op(4'b0000, 3'b000, 32'd100, 32'd200, 32'd0, 5'd20, 5'd21, 2'b11, 2'b11);
    @(posedge Clk); #1;
    chk("bub_valid", ValidOut, 0);
    chk("bub_ctrl", {MEMControlOut, WBControlOut}, 0);
    chk("bub_result_hold", ResultOut, 32'd8);
    chk("bub_data_hold", DataOut, 32'd77);
    chk("bub_rd_hold", RdOut, 5'd14);

    // Multiply 7 x 6: 32 busy cycles, result after edge 32
    @(negedge Clk);
    set_op(4'b1100, 3'b111, 32'd7, 32'd6, 32'd0, 5'd2, 5'd12, 2'b01, 2'b10);
    ValidIn = 1'b1;
    busy_cnt = 0;
    valid_early = 0;
    #1;
    for (int k = 0; k <= 32; k++) begin
      if (BusyOut) busy_cnt++;
      if (k == 32) chk("mul_busy_drop", BusyOut, 0);
      @(posedge Clk); #1;
      if (k < 32 && ValidOut !== 1'b0) valid_early++;
      if (k == 3) DataAIn = 32'd99;  // must be ignored mid-multiply
    end
    chk("mul_busy_cycles", busy_cnt, 32);
    chk("mul_valid_early", valid_early, 0);
    chk("mul_result", ResultOut, 32'd42);
    chk("mul_valid", ValidOut, 1);
    chk("mul_data", DataOut, 32'd6);
    chk("mul_rd", RdOut, 5'd12);
    chk("mul_ctrl", {MEMControlOut, WBControlOut}, 4'b0110);
    @(negedge Clk);
    set_op(4'b1000, 3'b000, 32'd1, 32'd2, 32'd0, 5'd4, 5'd5, 2'b00, 2'b01);
    #1 chk("b2b_busy", BusyOut, 0);
    @(posedge Clk); #1;
    chk("b2b_result", ResultOut, 32'd3);
    chk("b2b_rd", RdOut, 5'd5);
    chk("b2b_valid", ValidOut, 1);

    // Flush at step 10 of a multiply
    @(negedge Clk);
    set_op(4'b1100, 3'b111, 32'd3, 32'd3, 32'd0, 5'd1, 5'd6, 2'b01, 2'b11);
    repeat (11) @(posedge Clk);  // issue edge plus steps 1..10
    @(negedge Clk);
    FlushIn = 1'b1;
    #1 chk("flush_busy", BusyOut, 0);
    @(posedge Clk); #1;
    chk("flush_valid", ValidOut, 0);
    chk("flush_ctrl", {MEMControlOut, WBControlOut}, 0);
    @(negedge Clk);
    FlushIn = 1'b0;
    set_op(4'b1000, 3'b000, 32'd20, 32'd22, 32'd0, 5'd1, 5'd7, 2'b10, 2'b01);
    #1 chk("postflush_busy", BusyOut, 0);
    @(posedge Clk); #1;
    chk("postflush_result", ResultOut, 32'd42);
    chk("postflush_valid", ValidOut, 1);

    // Asynchronous reset in the middle of a multiply
    @(negedge Clk);
    set_op(4'b1100, 3'b111, 32'd5, 32'd5, 32'd0, 5'd1, 5'd8, 2'b11, 2'b11);
    repeat (5) @(posedge Clk);
    #3 RstN = 1'b0;
    #1;
    chk("arst_result", ResultOut, 0);
    chk("arst_data", DataOut, 0);
    chk("arst_rd", RdOut, 0);
    chk("arst_valid", ValidOut, 0);
    chk("arst_busy", BusyOut, 0);
    @(negedge Clk);
    RstN = 1'b1;
    ValidIn = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    set_op(4'b1000, 3'b000, 32'd2, 32'd3, 32'd0, 5'd1, 5'd9, 2'b00, 2'b10);
    ValidIn = 1'b1;
    @(posedge Clk); #1;
    chk("arst_add_result", ResultOut, 32'd5);
    chk("arst_add_valid", ValidOut, 1);

`ifdef EX_FORWARD_EN
    @(negedge Clk);
    set_op(4'b1000, 3'b000, 32'd0, 32'd5, 32'd0, 5'd1, 5'd3, 2'b00, 2'b10);
    ForwardAIn = 2'b01; MemResultIn = 32'd100;
    @(posedge Clk); #1;
    chk("fwd_a_result", ResultOut, 32'd105);
    @(negedge Clk);
    ForwardAIn = 2'b00; ForwardBIn = 2'b10; WbDataIn = 32'd3;
    @(posedge Clk); #1;
    chk("fwd_b_data", DataOut, 32'd3);
    chk("fwd_b_result", ResultOut, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Parametrised execute stage for the pipelined datapath: operand-source selection, single-cycle ALU, iterative multi-cycle multiplier and the EX/MEM pipeline register, with a stall handshake toward ID/EX. Sits between the ID/EX register and the MEM stage. It carries MEM/WB control and destination register through unchanged. Successor to the fixed 32-bit single-cycle EX stage.

## Interface
- DATA_WIDTH, 32: operand/result width, ≥8.
- REG_ADDR_WIDTH, 5: register index width.
- MEM_CTRL_WIDTH, 2: MEM control field width.
- WB_CTRL_WIDTH, 2: WB control field width.
- Clk  in  1  clock, rising edge.
- RstN  in  1  reset, asynchronous, active-low.
- ValidIn  in  1  ID/EX holds a valid instruction.
- FlushIn  in  1  synchronous flush of EX.
- EXControlIn  in  4  [3] RegDst (1=Rd, 0=Rt), [2:1] ALUOp, [0] ALUSrc (1=SEIn).
- MEMControlIn  in  MEM_CTRL_WIDTH  forwarded to MEM.
- WBControlIn  in  WB_CTRL_WIDTH  forwarded to WB.
- FunctIn  in  3  operation select when ALUOp=10.
- DataAIn, DataBIn, SEIn  in  DATA_WIDTH  operand A, operand B, sign-extended immediate.
- RtIn, RdIn  in  REG_ADDR_WIDTH  destination candidates.
- ResultOut, DataOut  out  DATA_WIDTH  registered ALU result; registered store data (B before ALUSrc mux).
- MEMControlOut  out  MEM_CTRL_WIDTH; WBControlOut  out  WB_CTRL_WIDTH; RdOut  out  REG_ADDR_WIDTH  registered.
- ValidOut  out  1  EX/MEM holds a valid instruction.
- BusyOut  out  1  combinational; ID/EX must hold inputs stable.

## Operation
- Operand B = ALUSrc ? SEIn : DataBIn.
- ALUOp: 00 add, 01 sub, 11 or, 10 decode FunctIn: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 signed slt (1/0 zero-extended), 110 sll A by B[$clog2(DATA_WIDTH)-1:0], 111 mul.
- All arithmetic modulo 2^DATA_WIDTH; no overflow flag. mul returns low DATA_WIDTH bits of product.
- FSM IDLE/MUL, down-counter $clog2(DATA_WIDTH) bits.
- IDLE, ValidIn, non-mul: EX/MEM captures result, controls, RdOut, ValidOut=1 on the edge.
- IDLE, ValidIn, mul: edge loads multiplicand/multiplier, clears accumulator, count=DATA_WIDTH-1, → MUL; EX/MEM takes bubble.
- MUL: one shift-add step per edge, count decrements; edge at count==0 performs final step, captures product plus controls into EX/MEM, ValidOut=1, → IDLE.
- BusyOut = (IDLE & ValidIn & mul) | (MUL & count≠0).
- ValidIn=0 in IDLE: bubble.
- Bubble: ValidOut=0, MEMControlOut=0, WBControlOut=0; ResultOut/DataOut/RdOut hold.
- FlushIn=1: next edge forces bubble, aborts MUL → IDLE; overrides ValidIn; BusyOut=0 that cycle.
- RstN low: immediate IDLE, all outputs 0, BusyOut 0.

## Timing
- Non-mul latency: 1 edge; throughput 1/cycle.
- Mul: issue edge + DATA_WIDTH step edges; result visible after edge DATA_WIDTH counted from issue (edge 0). BusyOut high DATA_WIDTH cycles; drops in the count==0 cycle so the next instruction is accepted on the completing edge.
- Inputs sampled only when BusyOut=0 or in the issue cycle; changes during MUL are ignored.
- Reset deassertion: first active edge one Clk after RstN rises.

## Configuration
- EX_FORWARD_EN defined: adds ForwardAIn, ForwardBIn (in, 2: 00 register, 01 MemResultIn, 10 WbDataIn, 11 register), MemResultIn, WbDataIn (in, DATA_WIDTH); forwarding muxes precede ALUSrc mux and feed DataOut; selection sampled at issue for mul.
- Undefined: ports absent; DataAIn/DataBIn used directly.

## Test plan
- A=4, B=8, EXControlIn=1101, FunctIn=010, SEIn=ffffffff, Rt=8, Rd=9 -> after 1 edge ResultOut=4, DataOut=8, RdOut=9, ValidOut=1, WBControlOut=11.
- ALUOp=00, A=ffffffff, B=1 -> ResultOut=0 (wrap); funct 101, A=ffffffff, B=1 -> ResultOut=1.
- mul 7×6, DATA_WIDTH=32 -> BusyOut high 32 cycles, ValidOut=0 edges 0–31, ResultOut=42 ValidOut=1 after edge 32; back-to-back add accepted on edge 32.
- FlushIn at step 10 of mul -> next edge ValidOut=0, BusyOut=0, IDLE; subsequent add completes in 1 edge.
- RstN low mid-mul, asynchronous to Clk -> all outputs 0 immediately; after release, add 2+3 -> 5.
- EX_FORWARD_EN, ForwardAIn=01, MemResultIn=100, B=5, add -> 105; ForwardBIn=10, WbDataIn=3 -> DataOut=3.
